// File: rtl/sequence_detector_param.sv
// sequence_detector_param
//   Serial bit-pattern detector with a runtime-programmable pattern of
//   1..MAX_LEN bits. It supports overlapping and non-overlapping match
//   modes, a per-bit input qualifier and a saturating hit counter.
//
// Ports
//   clk          clock, all logic on posedge
//   rst          synchronous active-high reset
//   cfg_valid    load cfg_pattern / cfg_len / cfg_overlap this cycle
//   cfg_pattern  pattern; bit [cfg_len-1] is received first, bit [0] last
//   cfg_len      pattern length, legal 1..MAX_LEN
//   cfg_overlap  1 = overlapping matches, 0 = non-overlapping
//   in_valid     a carries a valid stream bit this cycle
//   a            serial data bit
//   armed        detector configured and active (registered)
//   detected     one-cycle pulse per match (registered)
//   hit_count    saturating count of matches since last cfg/reset
//   cfg_err      one-cycle pulse after an illegal cfg_len
module sequence_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               a,
  output logic               armed,
  output logic               detected,
  output logic [CNT_W-1:0]   hit_count,
  output logic               cfg_err
);

  typedef enum logic [0:0] {
    UNCFG = 1'b0,
    ARMED = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  // The oldest history bit is never needed: the compare uses the post-shift
  // value, whose top bit is hist_q[MAX_LEN-2]. Only MAX_LEN-1 bits are kept.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   hit_q, hit_d;
  logic               armed_q, armed_d;
  logic               det_q, det_d;
  logic               err_q, err_d;

  logic [MAX_LEN-1:0] new_hist_s;
  logic [LEN_W-1:0]   new_fill_s;
  logic [MAX_LEN-1:0] mask_s;
  logic               cfg_legal_s;
  logic               match_s;

  // Next-state logic: configuration, history shift, match and counters.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    hit_d   = hit_q;
    det_d   = 1'b0;
    err_d   = 1'b0;

    new_hist_s = {hist_q, a};
    if (fill_q == LEN_W'(MAX_LEN)) begin
      new_fill_s = fill_q;
    end else begin
      new_fill_s = fill_q + LEN_W'(1);
    end
    // Low len_q bits set; a shift by MAX_LEN yields an all-ones mask.
    mask_s      = ~({MAX_LEN{1'b1}} << len_q);
    match_s     = (new_fill_s >= len_q) &&
                  ((new_hist_s & mask_s) == (pat_q & mask_s));
    cfg_legal_s = (cfg_len != LEN_W'(0)) && (cfg_len <= LEN_W'(MAX_LEN));

    // Configuration takes priority; a data bit in the same cycle is dropped.
    if (cfg_valid) begin
      hit_d = {CNT_W{1'b0}};
      if (cfg_legal_s) begin
        state_d = ARMED;
        pat_d   = cfg_pattern;
        len_d   = cfg_len;
        ovl_d   = cfg_overlap;
        hist_d  = {(MAX_LEN-1){1'b0}};
        fill_d  = {LEN_W{1'b0}};
      end else begin
        state_d = UNCFG;
        err_d   = 1'b1;
      end
    end else if ((state_q == ARMED) && in_valid) begin
      hist_d = new_hist_s[MAX_LEN-2:0];
      if (match_s) begin
        det_d = 1'b1;
        if (&hit_q) begin
          hit_d = hit_q;
        end else begin
          hit_d = hit_q + CNT_W'(1);
        end
        // Non-overlap mode restarts the fill so the next match needs len
        // fresh bits; history keeps shifting either way.
        if (ovl_q) begin
          fill_d = new_fill_s;
        end else begin
          fill_d = {LEN_W{1'b0}};
        end
      end else begin
        fill_d = new_fill_s;
      end
    end else begin
      hist_d = hist_q;
    end

    armed_d = (state_d == ARMED);
  end

  // State, configuration, history and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UNCFG;
      pat_q   <= {MAX_LEN{1'b0}};
      len_q   <= {LEN_W{1'b0}};
      ovl_q   <= 1'b0;
      hist_q  <= {(MAX_LEN-1){1'b0}};
      fill_q  <= {LEN_W{1'b0}};
      hit_q   <= {CNT_W{1'b0}};
      armed_q <= 1'b0;
      det_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      hit_q   <= hit_d;
      armed_q <= armed_d;
      det_q   <= det_d;
      err_q   <= err_d;
    end
  end

  assign armed     = armed_q;
  assign detected  = det_q;
  assign hit_count = hit_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_sequence_detector_param.sv
// tb_sequence_detector_param
//   Directed scenarios plus randomized traffic for sequence_detector_param,
//   checked every cycle against a behavioural model that keeps the accepted
//   bits in a queue and counts bits since configuration / last match.
module tb_sequence_detector_param;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cfg_valid = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               in_valid = 1'b0;
  logic               a = 1'b0;
  logic               armed, detected, cfg_err;
  logic [CNT_W-1:0]   hit_count;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;

  // Reference model state
  logic               m_armed = 1'b0;
  logic               m_det = 1'b0;
  logic               m_err = 1'b0;
  int                 m_hit = 0;
  logic [MAX_LEN-1:0] m_pat = '0;
  int                 m_len = 0;
  logic               m_ovl = 1'b0;
  logic               m_bits[$];
  int                 m_fresh = 0;

  sequence_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .a(a), .armed(armed), .detected(detected), .hit_count(hit_count),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural model: applied with the inputs seen at a rising edge.
  task automatic model_edge();
    bit ok;
    m_det = 1'b0;
    m_err = 1'b0;
    if (rst) begin
      m_armed = 1'b0; m_hit = 0; m_pat = '0; m_len = 0; m_ovl = 1'b0;
      m_bits.delete(); m_fresh = 0;
    end else if (cfg_valid) begin
      m_hit = 0;
      if (cfg_len >= 1 && cfg_len <= MAX_LEN) begin
        m_armed = 1'b1; m_pat = cfg_pattern; m_len = int'(cfg_len);
        m_ovl = cfg_overlap; m_bits.delete(); m_fresh = 0;
      end else begin
        m_armed = 1'b0; m_err = 1'b1;
      end
    end else if (m_armed && in_valid) begin
      m_bits.push_back(a);
      if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
      m_fresh++;
      ok = (m_fresh >= m_len);
      if (ok) begin
        // Most recent bit is pattern[0], the one len-1 bits back is pattern[len-1].
        for (int i = 0; i < m_len; i++)
          if (m_bits[m_bits.size()-1-i] != m_pat[i]) ok = 1'b0;
      end
      if (ok) begin
        m_det = 1'b1;
        if (m_hit < (1 << CNT_W) - 1) m_hit++;
        if (!m_ovl) m_fresh = 0;
      end
    end
  endtask

  task automatic step(input logic r, input logic cv, input logic [MAX_LEN-1:0] p,
                      input logic [LEN_W-1:0] l, input logic ov,
                      input logic iv, input logic d);
    rst = r; cfg_valid = cv; cfg_pattern = p; cfg_len = l; cfg_overlap = ov;
    in_valid = iv; a = d;
    @(posedge clk);
    model_edge();
    #1;
    check_eq("armed", 32'(armed), 32'(m_armed));
    check_eq("detected", 32'(detected), 32'(m_det));
    check_eq("hit_count", 32'(hit_count), 32'(m_hit));
    check_eq("cfg_err", 32'(cfg_err), 32'(m_err));
    if (detected) pulses++;
  endtask

  task automatic cfg(input logic [MAX_LEN-1:0] p, input int l, input logic ov);
    step(1'b0, 1'b1, p, LEN_W'(l), ov, 1'b0, 1'b0);
  endtask

  task automatic bit_in(input logic d);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, d);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic stream(input logic [15:0] s, input int n);
    for (int i = n - 1; i >= 0; i--) bit_in(s[i]);
  endtask

  initial begin
    logic [15:0] s;
    // Reset state
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    check_eq("rst_armed", 32'(armed), 32'd0);
    check_eq("rst_hits", 32'(hit_count), 32'd0);

    // Overlap: pulses after bits 6 and 10
    s = 16'b1100110011;
    cfg(8'b00110011, 6, 1'b1);
    pulses = 0;
    stream(s, 10);
    check_eq("t1_pulses", 32'(pulses), 32'd2);
    check_eq("t1_hits", 32'(hit_count), 32'd2);

    // Non-overlap: single pulse
    cfg(8'b00110011, 6, 1'b0);
    pulses = 0;
    stream(s, 10);
    check_eq("t2_pulses", 32'(pulses), 32'd1);
    check_eq("t2_hits", 32'(hit_count), 32'd1);

    // Gaps between bits 2 and 3
    cfg(8'b00001010, 4, 1'b1);
    pulses = 0;
    bit_in(1'b1); bit_in(1'b0);
    idle(); idle(); idle();
    check_eq("t3_gap_pulses", 32'(pulses), 32'd0);
    bit_in(1'b1); bit_in(1'b0);
    check_eq("t3_det", 32'(detected), 32'd1);
    idle();
    check_eq("t3_pulses", 32'(pulses), 32'd1);

    // len=1, saturation at 3
    cfg(8'b00000001, 1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bit_in(1'b1);
      check_eq("t4_det", 32'(detected), 32'd1);
      check_eq("t4_hits", 32'(hit_count), (i < 3) ? 32'(i + 1) : 32'd3);
    end

    // Illegal length while armed, then stream, then legal reload
    cfg(8'b00110011, 0, 1'b1);
    check_eq("t5_err", 32'(cfg_err), 32'd1);
    check_eq("t5_armed", 32'(armed), 32'd0);
    pulses = 0;
    stream(16'b110011, 6);
    check_eq("t5_pulses", 32'(pulses), 32'd0);
    check_eq("t5_err_gone", 32'(cfg_err), 32'd0);
    cfg(8'b00110011, 9, 1'b1);
    check_eq("t5_err_big", 32'(cfg_err), 32'd1);
    cfg(8'b00110011, 6, 1'b1);
    check_eq("t5_rearm", 32'(armed), 32'd1);
    check_eq("t5_hits0", 32'(hit_count), 32'd0);

    // Reset mid-stream, then cfg with a same-cycle data bit
    stream(16'b11001, 5);
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    pulses = 0;
    bit_in(1'b1);
    check_eq("t6_pulses", 32'(pulses), 32'd0);
    check_eq("t6_armed", 32'(armed), 32'd0);
    step(1'b0, 1'b1, 8'b00000011, 4'd2, 1'b1, 1'b1, 1'b1);
    bit_in(1'b1);
    check_eq("t6_dropped", 32'(detected), 32'd0);
    bit_in(1'b1);
    check_eq("t6_match", 32'(detected), 32'd1);

    // Full-length pattern
    cfg(8'b10110010, 8, 1'b0);
    stream(16'b1011001010110010, 16);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      int r = $urandom_range(0, 99);
      if (r < 1) begin
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 1'($urandom));
      end else if (r < 5) begin
        int l = ($urandom_range(0, 9) < 8) ? $urandom_range(1, 4)
                                            : $urandom_range(0, 15);
        step(1'b0, 1'b1, MAX_LEN'($urandom), LEN_W'(l), 1'($urandom),
             1'($urandom), 1'($urandom));
      end else begin
        step(1'b0, 1'b0, '0, '0, 1'b0, ($urandom_range(0, 9) < 8), 1'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
